// File: rtl/localbus_pkg.sv
`default_nettype none
// =====================================================================
// localbus_pkg - LocalBus command word layout, op codes and FSM states
// Revision: 1.0
// =====================================================================
package localbus_pkg;

   localparam logic [1:0] OP_WR  = 2'b01;
   localparam logic [1:0] OP_RD  = 2'b10;
   localparam logic [1:0] OP_RSP = 2'b11;

   localparam int OP_MSB   = 63;
   localparam int OP_LSB   = 62;
   localparam int TAG_MSB  = 61;
   localparam int TAG_LSB  = 56;
   localparam int ADDR_MSB = 55;
   localparam int ADDR_LSB = 32;
   localparam int DATA_MSB = 31;
   localparam int DATA_LSB = 0;

   localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   function automatic logic [63:0] pack_cmd(input logic [1:0]  op,
                                            input logic [5:0]  tag,
                                            input logic [23:0] addr,
                                            input logic [31:0] data);
      return {op, tag, addr, data};
   endfunction

endpackage
`default_nettype wire

// File: rtl/localbus_cmd_issuer.sv
`default_nettype none
// =====================================================================
// localbus_cmd_issuer - issues host CSR requests as LocalBus commands
// Revision: 1.0
// =====================================================================
module localbus_cmd_issuer
   import localbus_pkg::*;
#(
   parameter int TIMEOUT_CYC = 1024,
   parameter int CNT_W       = 16
) (
   input  logic             i_sys_clk,
   input  logic             i_sys_rst_n,
   input  logic             i_req_valid,
   output logic             o_req_ready,
   input  logic             i_req_wr,
   input  logic [23:0]      i_req_addr,
   input  logic [31:0]      i_req_wdata,
   output logic             o_rsp_valid,
   output logic [31:0]      o_rsp_rdata,
   output logic             o_rsp_err,
   output logic             o_lb_command_wr,
   output logic [63:0]      o_lb_command,
   input  logic             i_lb_allmostfull,
   input  logic             i_lb_rsp_wr,
   input  logic [63:0]      i_lb_rsp,
   output logic [CNT_W-1:0] o_timeout_cnt,
   output logic [CNT_W-1:0] o_stray_cnt
);

   localparam int                WAIT_W    = $clog2(TIMEOUT_CYC + 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYC - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

   state_e            state_q,       state_d;
   logic              req_wr_q,      req_wr_d;
   logic [23:0]       req_addr_q,    req_addr_d;
   logic [31:0]       req_wdata_q,   req_wdata_d;
   logic [5:0]        tag_q,         tag_d;
   logic [5:0]        cur_tag_q,     cur_tag_d;
   logic [WAIT_W-1:0] wait_cnt_q,    wait_cnt_d;
   logic              cmd_wr_q,      cmd_wr_d;
   logic [63:0]       cmd_q,         cmd_d;
   logic              rsp_valid_q,   rsp_valid_d;
   logic [31:0]       rsp_rdata_q,   rsp_rdata_d;
   logic              rsp_err_q,     rsp_err_d;
   logic [CNT_W-1:0]  timeout_cnt_q, timeout_cnt_d;
   logic [CNT_W-1:0]  stray_cnt_q,   stray_cnt_d;

   logic [1:0]  rsp_op;
   logic [5:0]  rsp_tag;
   logic [31:0] rsp_data;
   logic        rsp_match;
   logic        rsp_stray;
   logic        timeout_hit;
   logic        unused_rsp_addr;

   assign rsp_op          = i_lb_rsp[OP_MSB:OP_LSB];
   assign rsp_tag         = i_lb_rsp[TAG_MSB:TAG_LSB];
   assign rsp_data        = i_lb_rsp[DATA_MSB:DATA_LSB];
   assign unused_rsp_addr = ^i_lb_rsp[ADDR_MSB:ADDR_LSB];

   // Only a read response for the outstanding tag, seen while waiting, completes a read.
   assign rsp_match   = (state_q == ST_WAIT) && i_lb_rsp_wr &&
                        (rsp_op == OP_RSP) && (rsp_tag == cur_tag_q);
   assign rsp_stray   = i_lb_rsp_wr && !rsp_match;
   assign timeout_hit = (state_q == ST_WAIT) && (wait_cnt_q == WAIT_LAST);

   always_comb begin
      state_d       = state_q;
      req_wr_d      = req_wr_q;
      req_addr_d    = req_addr_q;
      req_wdata_d   = req_wdata_q;
      tag_d         = tag_q;
      cur_tag_d     = cur_tag_q;
      wait_cnt_d    = wait_cnt_q;
      cmd_wr_d      = 1'b0;
      cmd_d         = cmd_q;
      rsp_valid_d   = 1'b0;
      rsp_rdata_d   = rsp_rdata_q;
      rsp_err_d     = rsp_err_q;
      timeout_cnt_d = timeout_cnt_q;
      stray_cnt_d   = stray_cnt_q;

      case (state_q)
         ST_IDLE: begin
            if (i_req_valid) begin
               req_wr_d    = i_req_wr;
               req_addr_d  = i_req_addr;
               req_wdata_d = i_req_wdata;
               state_d     = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (!i_lb_allmostfull) begin
               cmd_wr_d = 1'b1;
               if (req_wr_q) begin
                  cmd_d       = pack_cmd(OP_WR, 6'd0, req_addr_q, req_wdata_q);
                  rsp_rdata_d = 32'd0;
                  rsp_err_d   = 1'b0;
                  state_d     = ST_DONE;
               end else begin
                  cmd_d      = pack_cmd(OP_RD, tag_q, req_addr_q, 32'd0);
                  cur_tag_d  = tag_q;
                  tag_d      = tag_q + 6'd1;
                  wait_cnt_d = '0;
                  state_d    = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            if (rsp_match) begin
               rsp_rdata_d = rsp_data;
               rsp_err_d   = 1'b0;
               state_d     = ST_DONE;
            end else if (timeout_hit) begin
               rsp_rdata_d = TIMEOUT_DATA;
               rsp_err_d   = 1'b1;
               if (timeout_cnt_q != CNT_MAX) begin
                  timeout_cnt_d = timeout_cnt_q + CNT_W'(1);
               end
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            rsp_valid_d = 1'b1;
            state_d     = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (rsp_stray && (stray_cnt_q != CNT_MAX)) begin
         stray_cnt_d = stray_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge i_sys_clk) begin
      if (!i_sys_rst_n) begin
         state_q       <= ST_IDLE;
         req_wr_q      <= 1'b0;
         req_addr_q    <= '0;
         req_wdata_q   <= '0;
         tag_q         <= '0;
         cur_tag_q     <= '0;
         wait_cnt_q    <= '0;
         cmd_wr_q      <= 1'b0;
         cmd_q         <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_rdata_q   <= '0;
         rsp_err_q     <= 1'b0;
         timeout_cnt_q <= '0;
         stray_cnt_q   <= '0;
      end else begin
         state_q       <= state_d;
         req_wr_q      <= req_wr_d;
         req_addr_q    <= req_addr_d;
         req_wdata_q   <= req_wdata_d;
         tag_q         <= tag_d;
         cur_tag_q     <= cur_tag_d;
         wait_cnt_q    <= wait_cnt_d;
         cmd_wr_q      <= cmd_wr_d;
         cmd_q         <= cmd_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_rdata_q   <= rsp_rdata_d;
         rsp_err_q     <= rsp_err_d;
         timeout_cnt_q <= timeout_cnt_d;
         stray_cnt_q   <= stray_cnt_d;
      end
   end

   assign o_req_ready     = (state_q == ST_IDLE);
   assign o_rsp_valid     = rsp_valid_q;
   assign o_rsp_rdata     = rsp_rdata_q;
   assign o_rsp_err       = rsp_err_q;
   assign o_lb_command_wr = cmd_wr_q;
   assign o_lb_command    = cmd_q;
   assign o_timeout_cnt   = timeout_cnt_q;
   assign o_stray_cnt     = stray_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_localbus_cmd_issuer.sv
`default_nettype none
// =====================================================================
// tb_localbus_cmd_issuer - randomized bench with a transaction-level model
// Revision: 1.0
// =====================================================================
module tb_localbus_cmd_issuer;

   localparam int TO   = 16;
   localparam int CW   = 4;
   localparam int CMAX = 15;

   logic          clk;
   logic          rst_n;
   logic          req_valid;
   logic          req_ready;
   logic          req_wr;
   logic [23:0]   req_addr;
   logic [31:0]   req_wdata;
   logic          rsp_valid;
   logic [31:0]   rsp_rdata;
   logic          rsp_err;
   logic          lb_cmd_wr;
   logic [63:0]   lb_cmd;
   logic          af;
   logic          lb_rsp_wr;
   logic [63:0]   lb_rsp;
   logic [CW-1:0] timeout_cnt;
   logic [CW-1:0] stray_cnt;

   int total = 0;
   int bad   = 0;

   // transaction-level model state
   int exp_tag      = 0;
   int exp_strays   = 0;
   int exp_timeouts = 0;

   // passive monitor state
   int   strobe_cnt = 0;
   int   rsp_cnt    = 0;
   logic prev_wr    = 1'b0;
   logic prev_v     = 1'b0;
   logic b2b_wr     = 1'b0;
   logic b2b_v      = 1'b0;

   localbus_cmd_issuer #(.TIMEOUT_CYC(TO), .CNT_W(CW)) dut (
      .i_sys_clk       (clk),
      .i_sys_rst_n     (rst_n),
      .i_req_valid     (req_valid),
      .o_req_ready     (req_ready),
      .i_req_wr        (req_wr),
      .i_req_addr      (req_addr),
      .i_req_wdata     (req_wdata),
      .o_rsp_valid     (rsp_valid),
      .o_rsp_rdata     (rsp_rdata),
      .o_rsp_err       (rsp_err),
      .o_lb_command_wr (lb_cmd_wr),
      .o_lb_command    (lb_cmd),
      .i_lb_allmostfull(af),
      .i_lb_rsp_wr     (lb_rsp_wr),
      .i_lb_rsp        (lb_rsp),
      .o_timeout_cnt   (timeout_cnt),
      .o_stray_cnt     (stray_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      prev_wr <= lb_cmd_wr;
      prev_v  <= rsp_valid;
      if (lb_cmd_wr === 1'b1) begin
         strobe_cnt <= strobe_cnt + 1;
         if (prev_wr === 1'b1) b2b_wr <= 1'b1;
      end
      if (rsp_valid === 1'b1) begin
         rsp_cnt <= rsp_cnt + 1;
         if (prev_v === 1'b1) b2b_v <= 1'b1;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
      $fatal(1, "watchdog");
   end

   function automatic int sat(input int x);
      return (x > CMAX) ? CMAX : x;
   endfunction

   // All tasks are entered and left 1 time unit after a rising edge.
   task automatic issue_req(input logic wr, input logic [23:0] a, input logic [31:0] d);
      for (int i = 0; i < 50; i++) begin
         if (req_ready) break;
         @(posedge clk); #1;
      end
      req_valid = 1'b1; req_wr = wr; req_addr = a; req_wdata = d;
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   // hold >= 0: allmostfull high for the first 'hold' cycles; hold < 0: random with pct.
   task automatic wait_strobe(input int hold, input int pct, output int gap, output int fz,
                              output logic [63:0] word);
      logic v;
      gap = -1; fz = -1; word = 'x;
      for (int k = 1; k <= 40; k++) begin
         v = (hold >= 0) ? (k <= hold) : ($urandom_range(99) < 32'(pct));
         if (k >= 30) v = 1'b0;
         if (fz < 0 && !v) fz = k;
         af = v;
         @(posedge clk); #1;
         if (lb_cmd_wr) begin
            gap = k; word = lb_cmd;
            break;
         end
      end
      af = 1'b0;
   endtask

   task automatic run_write(input logic [23:0] a, input logic [31:0] d, input int hold, input int pct,
                            output int gap, output int fz, output logic [63:0] word,
                            output int lat, output logic [31:0] rd, output logic er);
      lat = -1; rd = 'x; er = 1'bx;
      issue_req(1'b1, a, d);
      wait_strobe(hold, pct, gap, fz, word);
      if (gap < 0) return;
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk); #1;
         if (rsp_valid) begin lat = k; rd = rsp_rdata; er = rsp_err; break; end
      end
   endtask

   // resp_at/stray_at: cycle after the strobe at which a response is sampled (0 = none).
   task automatic run_read(input logic [23:0] a, input int hold, input int pct,
                           input int resp_at, input int stray_at, input logic [31:0] rd_in,
                           output int gap, output int fz, output logic [63:0] word,
                           output int lat, output logic [31:0] rd, output logic er);
      logic [5:0] t;
      t = 6'(exp_tag);
      lat = -1; rd = 'x; er = 1'bx;
      issue_req(1'b0, a, 32'h0);
      wait_strobe(hold, pct, gap, fz, word);
      if (gap < 0) return;
      for (int k = 1; k <= TO + 4; k++) begin
         lb_rsp_wr = 1'b0;
         if (k == resp_at) begin
            lb_rsp_wr = 1'b1;
            lb_rsp    = {2'b11, t, 24'($urandom), rd_in};
         end else if (k == stray_at) begin
            lb_rsp_wr = 1'b1;
            if ($urandom_range(1) == 0)
               lb_rsp = {2'b11, t ^ 6'(1 + $urandom_range(62)), 24'($urandom), $urandom};
            else
               lb_rsp = {2'($urandom_range(2)), t, 24'($urandom), $urandom};
         end
         @(posedge clk); #1;
         lb_rsp_wr = 1'b0;
         if (rsp_valid) begin lat = k; rd = rsp_rdata; er = rsp_err; break; end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
      af = 1'b0; lb_rsp_wr = 1'b0; lb_rsp = '0;
      repeat (3) @(posedge clk);
      #1;
      total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", req_ready); end
      total++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin
         bad++; $display("FAIL reset_rsp got v=%b e=%b d=%h want 0/0/0", rsp_valid, rsp_err, rsp_rdata); end
      total++; if (lb_cmd_wr !== 1'b0 || lb_cmd !== 64'h0) begin
         bad++; $display("FAIL reset_cmd got wr=%b cmd=%h want 0/0", lb_cmd_wr, lb_cmd); end
      total++; if (timeout_cnt !== '0 || stray_cnt !== '0) begin
         bad++; $display("FAIL reset_cnt got to=%0d st=%0d want 0/0", timeout_cnt, stray_cnt); end
      rst_n = 1'b1;
      @(posedge clk); #1;
      total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready got=%b want=1", req_ready); end
      exp_tag = 0; exp_strays = 0; exp_timeouts = 0;
   endtask

   task automatic test_write();
      int gap, fz, lat; logic [63:0] w; logic [31:0] rd; logic er;
      run_write(24'h000010, 32'h1234_5678, 0, 0, gap, fz, w, lat, rd, er);
      total++; if (w !== 64'h4000_0010_1234_5678) begin bad++; $display("FAIL write_word got=%h want=4000001012345678", w); end
      total++; if (gap !== 1) begin bad++; $display("FAIL write_strobe_lat got=%0d want=1", gap); end
      total++; if (lat !== 1) begin bad++; $display("FAIL write_rsp_lat got=%0d want=1", lat); end
      total++; if (er !== 1'b0 || rd !== 32'h0) begin bad++; $display("FAIL write_rsp got e=%b d=%h want 0/0", er, rd); end
      total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL write_ready_after got=%b want=1", req_ready); end
   endtask

   task automatic test_read();
      int gap, fz, lat; logic [63:0] w; logic [31:0] rd; logic er;
      run_read(24'h000020, 0, 0, 5, 0, 32'hCAFE_F00D, gap, fz, w, lat, rd, er);
      total++; if (w !== 64'h8000_0020_0000_0000) begin bad++; $display("FAIL read_word got=%h want=8000002000000000", w); end
      total++; if (gap !== 1) begin bad++; $display("FAIL read_strobe_lat got=%0d want=1", gap); end
      total++; if (lat !== 6) begin bad++; $display("FAIL read_rsp_lat got=%0d want=6", lat); end
      total++; if (er !== 1'b0 || rd !== 32'hCAFE_F00D) begin bad++; $display("FAIL read_rsp got e=%b d=%h want 0/cafef00d", er, rd); end
      exp_tag = 1;
      run_read(24'h000024, 0, 0, 1, 0, 32'h0BAD_CAFE, gap, fz, w, lat, rd, er);
      total++; if (w[61:56] !== 6'd1) begin bad++; $display("FAIL read_tag1 got=%0d want=1", w[61:56]); end
      total++; if (lat !== 2 || rd !== 32'h0BAD_CAFE) begin bad++; $display("FAIL read2_rsp got lat=%0d d=%h want 2/0badcafe", lat, rd); end
      exp_tag = 2;
   endtask

   task automatic test_backpressure();
      int gap, fz, lat, s0; logic [63:0] w; logic [31:0] rd; logic er;
      s0 = strobe_cnt;
      run_write(24'hABCDEF, 32'h5555_AAAA, 7, 0, gap, fz, w, lat, rd, er);
      total++; if (gap !== 8) begin bad++; $display("FAIL bp_strobe_delay got=%0d want=8", gap); end
      total++; if (strobe_cnt - s0 !== 1) begin bad++; $display("FAIL bp_strobe_count got=%0d want=1", strobe_cnt - s0); end
      total++; if (w !== 64'h40AB_CDEF_5555_AAAA || lat !== 1) begin
         bad++; $display("FAIL bp_write got w=%h lat=%0d want 40abcdef5555aaaa/1", w, lat); end
      s0 = strobe_cnt;
      run_read(24'h000100, 3, 0, 2, 0, 32'h1111_2222, gap, fz, w, lat, rd, er);
      total++; if (gap !== 4 || strobe_cnt - s0 !== 1) begin
         bad++; $display("FAIL bp_read got gap=%0d n=%0d want 4/1", gap, strobe_cnt - s0); end
      total++; if (w !== {2'b10, 6'(exp_tag), 24'h000100, 32'h0}) begin bad++; $display("FAIL bp_read_word got=%h", w); end
      exp_tag = (exp_tag + 1) % 64;
   endtask

   task automatic test_timeout();
      int gap, fz, lat; logic [63:0] w; logic [31:0] rd; logic er;
      run_read(24'h000030, 0, 0, 0, 5, 32'h0, gap, fz, w, lat, rd, er);
      exp_tag = (exp_tag + 1) % 64; exp_timeouts++; exp_strays++;
      total++; if (lat !== TO + 1) begin bad++; $display("FAIL to_lat got=%0d want=%0d", lat, TO + 1); end
      total++; if (er !== 1'b1 || rd !== 32'hDEAD_BEEF) begin bad++; $display("FAIL to_rsp got e=%b d=%h want 1/deadbeef", er, rd); end
      total++; if (timeout_cnt !== CW'(1)) begin bad++; $display("FAIL to_cnt got=%0d want=1", timeout_cnt); end
      total++; if (stray_cnt !== CW'(1)) begin bad++; $display("FAIL to_stray got=%0d want=1", stray_cnt); end
   endtask

   task automatic test_tag_wrap();
      int gap, fz, lat, ra; logic [63:0] w; logic [31:0] rd, d; logic er; bit wrapped;
      wrapped = 1'b0;
      for (int i = 0; i < 64; i++) begin
         ra = int'($urandom_range(1, 4)); d = $urandom;
         run_read(24'($urandom), 0, 0, ra, 0, d, gap, fz, w, lat, rd, er);
         total++; if (w[61:56] !== 6'(exp_tag)) begin bad++; $display("FAIL wrap_tag[%0d] got=%0d want=%0d", i, w[61:56], exp_tag); end
         total++; if (rd !== d || er !== 1'b0 || lat !== ra + 1) begin
            bad++; $display("FAIL wrap_rsp[%0d] got d=%h e=%b lat=%0d want %h/0/%0d", i, rd, er, lat, d, ra + 1); end
         if (exp_tag == 63) wrapped = 1'b1;
         exp_tag = (exp_tag + 1) % 64;
      end
      total++; if (!wrapped || exp_tag !== int'(6'(exp_tag))) begin bad++; $display("FAIL wrap_seen got=%0d want=1", wrapped); end
      d = 32'h600D_F00D;
      run_read(24'h000040, 0, 0, TO, 0, d, gap, fz, w, lat, rd, er);
      exp_tag = (exp_tag + 1) % 64;
      total++; if (er !== 1'b0 || rd !== d || lat !== TO + 1) begin
         bad++; $display("FAIL edge_match got e=%b d=%h lat=%0d want 0/%h/%0d", er, rd, lat, d, TO + 1); end
      total++; if (timeout_cnt !== CW'(sat(exp_timeouts))) begin
         bad++; $display("FAIL edge_match_cnt got=%0d want=%0d", timeout_cnt, sat(exp_timeouts)); end
   endtask

   task automatic test_random();
      logic wr; logic [23:0] a; logic [31:0] d, rd, erd; logic er, eer;
      int ra, sa, smax, gap, fz, lat, elat; logic [63:0] w, ew;
      for (int i = 0; i < 40; i++) begin
         wr = 1'($urandom_range(1)); a = 24'($urandom); d = $urandom;
         if (wr) begin
            ew = {2'b01, 6'd0, a, d};
            run_write(a, d, -1, 40, gap, fz, w, lat, rd, er);
            elat = 1; erd = 32'h0; eer = 1'b0;
         end else begin
            ra = ($urandom_range(3) == 0) ? 0 : int'($urandom_range(1, TO));
            smax = (ra == 0) ? TO - 1 : ra - 1;
            sa = 0;
            if (smax >= 1 && $urandom_range(2) == 0) sa = int'($urandom_range(1, smax));
            ew = {2'b10, 6'(exp_tag), a, 32'h0};
            run_read(a, -1, 40, ra, sa, d, gap, fz, w, lat, rd, er);
            if (ra > 0) begin elat = ra + 1; erd = d; eer = 1'b0; end
            else begin elat = TO + 1; erd = 32'hDEAD_BEEF; eer = 1'b1; exp_timeouts++; end
            if (sa > 0) exp_strays++;
            exp_tag = (exp_tag + 1) % 64;
         end
         total++; if (w !== ew) begin bad++; $display("FAIL rnd_word[%0d] got=%h want=%h", i, w, ew); end
         total++; if (gap !== fz) begin bad++; $display("FAIL rnd_bp[%0d] got=%0d want=%0d", i, gap, fz); end
         total++; if (lat !== elat || rd !== erd || er !== eer) begin
            bad++; $display("FAIL rnd_rsp[%0d] got lat=%0d d=%h e=%b want %0d/%h/%b", i, lat, rd, er, elat, erd, eer); end
         if ($urandom_range(3) == 0) begin
            lb_rsp_wr = 1'b1; lb_rsp = {$urandom, $urandom};
            @(posedge clk); #1;
            lb_rsp_wr = 1'b0; exp_strays++;
         end
         total++; if (timeout_cnt !== CW'(sat(exp_timeouts)) || stray_cnt !== CW'(sat(exp_strays))) begin
            bad++; $display("FAIL rnd_cnt[%0d] got to=%0d st=%0d want %0d/%0d", i, timeout_cnt, stray_cnt,
                            sat(exp_timeouts), sat(exp_strays)); end
      end
   endtask

   task automatic test_saturation();
      int gap, fz, lat; logic [63:0] w; logic [31:0] rd; logic er;
      for (int i = 0; i < 20; i++) begin
         lb_rsp_wr = 1'b1;
         lb_rsp = {2'b11, 6'(exp_tag + 63), 24'($urandom), $urandom};
         @(posedge clk); #1;
         lb_rsp_wr = 1'b0; exp_strays++;
      end
      total++; if (stray_cnt !== CW'(sat(exp_strays))) begin
         bad++; $display("FAIL stray_sat got=%0d want=%0d", stray_cnt, sat(exp_strays)); end
      while (exp_timeouts < CMAX + 2) begin
         run_read(24'($urandom), 0, 0, 0, 0, 32'h0, gap, fz, w, lat, rd, er);
         exp_timeouts++; exp_tag = (exp_tag + 1) % 64;
      end
      total++; if (timeout_cnt !== CW'(sat(exp_timeouts))) begin
         bad++; $display("FAIL timeout_sat got=%0d want=%0d", timeout_cnt, sat(exp_timeouts)); end
   endtask

   task automatic test_reset_wait();
      int gap, fz, lat, r0; logic [63:0] w; logic [31:0] rd; logic er;
      issue_req(1'b0, 24'h000050, 32'h0);
      wait_strobe(0, 0, gap, fz, w);
      repeat (3) begin @(posedge clk); #1; end
      r0 = rsp_cnt;
      rst_n = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      rst_n = 1'b1;
      @(posedge clk); #1;
      exp_tag = 0; exp_strays = 0; exp_timeouts = 0;
      total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rstw_ready got=%b want=1", req_ready); end
      total++; if (timeout_cnt !== '0 || stray_cnt !== '0) begin
         bad++; $display("FAIL rstw_cnt got to=%0d st=%0d want 0/0", timeout_cnt, stray_cnt); end
      repeat (TO + 4) begin @(posedge clk); #1; end
      total++; if (rsp_cnt !== r0) begin bad++; $display("FAIL rstw_no_rsp got=%0d want=%0d", rsp_cnt - r0, 0); end
      run_read(24'h000054, 0, 0, 2, 0, 32'h7777_0000, gap, fz, w, lat, rd, er);
      total++; if (w !== 64'h8000_0054_0000_0000) begin bad++; $display("FAIL rstw_tag got=%h want=8000005400000000", w); end
      exp_tag = 1;
   endtask

   task automatic test_invariants();
      total++; if (b2b_wr !== 1'b0) begin bad++; $display("FAIL strobe_b2b got=%b want=0", b2b_wr); end
      total++; if (b2b_v !== 1'b0) begin bad++; $display("FAIL rsp_pulse_b2b got=%b want=0", b2b_v); end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_backpressure();
      test_timeout();
      test_tag_wrap();
      test_random();
      test_saturation();
      test_reset_wait();
      test_invariants();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
